// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : PC + req/ack instruction fetch into a 2-entry {instr, pc} FIFO,
//           with redirect squash/restart through a RUN/FLUSH machine.
// Revision: 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [ADDR_WIDTH-1:0]  out_pc_next
);

    localparam logic [0:0]            S_RUN   = 1'b0;
    localparam logic [0:0]            S_FLUSH = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] C_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] C_ALIGN = ~ADDR_WIDTH'(3);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [ADDR_WIDTH-1:0]  r_tgt;
    logic [INSTR_WIDTH-1:0] r_instr [2];
    logic [ADDR_WIDTH-1:0]  r_pc    [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic                   w_xfer;
    logic                   w_push;
    logic                   w_pop;
    logic [ADDR_WIDTH-1:0]  w_redirect_pc;

    assign w_redirect_pc = redirect_pc & C_ALIGN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                // Squashing a pending request must wait for its ack.
                if (redirect && imem_req && !imem_ack) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (imem_ack) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (!reset) begin
            imem_req = (r_state == S_FLUSH) ? 1'b1 : (r_count < 2'd2);
        end
        w_xfer = imem_req && imem_ack;
        w_push = (r_state == S_RUN) && w_xfer && !redirect;
        w_pop  = out_valid && out_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_tgt      <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (redirect) begin
                        if (imem_req && !imem_ack) begin
                            r_tgt <= w_redirect_pc;
                        end else begin
                            r_fetch_pc <= w_redirect_pc;
                        end
                    end else if (w_xfer) begin
                        r_fetch_pc <= r_fetch_pc + C_STEP;
                    end
                end
                default: begin
                    if (imem_ack) begin
                        r_fetch_pc <= redirect ? w_redirect_pc : r_tgt;
                    end else if (redirect) begin
                        r_tgt <= w_redirect_pc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= imem_rdata;
                r_pc[r_wr_ptr]    <= r_fetch_pc;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign out_valid   = (r_count != 2'd0);
    assign out_instr   = r_instr[r_rd_ptr];
    assign out_pc      = r_pc[r_rd_ptr];
    assign out_pc_next = r_pc[r_rd_ptr] + C_STEP;

endmodule
`default_nettype wire
